// File: rtl/nanov_alu_seq.sv
// Bit-serial ALU sequencer: streams one XLEN-bit op LSB-first through an external 1-bit slice; optional abort via NANOV_ALU_SEQ_ABORT_EN.
// Latency XLEN+1 cycles accept-to-done, one op per XLEN+2 cycles; start is ignored (not queued) outside IDLE.
module nanov_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
`ifdef NANOV_ALU_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_op,
  output logic            alu_a,
  output logic            alu_b,
  output logic            alu_cy_in,
  input  logic            alu_d,
  input  logic            alu_cy_out,
  input  logic            alu_lts
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_sh, b_sh;
  logic [XLEN-2:0] res_sh;
  logic [XLEN-1:0] res_asm, res_fix;
  logic            last_bit;
  logic            abort_req;

`ifdef NANOV_ALU_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_bit = (cnt == CW'(XLEN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (abort_req)     state_nxt = S_IDLE;
        else if (last_bit) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Final slice bit joins the assembled value combinationally so result can load on the last RUN edge.
  always_comb begin
    res_asm = {alu_d, res_sh};
    case (op_q)
      4'b0010: res_fix = {{(XLEN-1){1'b0}}, alu_lts};
      4'b0011: res_fix = {{(XLEN-1){1'b0}}, ~alu_cy_out};
      default: res_fix = res_asm;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      carry  <= 1'b0;
      op_q   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            carry <= 1'b0;
          end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_asm[XLEN-1:1];
            carry  <= alu_cy_out;
            cnt    <= cnt + CW'(1);
            if (last_bit) result <= res_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign alu_op = op_q;
  assign alu_a  = a_sh[0];
  assign alu_b  = b_sh[0];
  // First bit injects the +1 of the two's-complement subtract for SUB/SLT/SLTU.
  assign alu_cy_in = (cnt == '0) ? (op_q[1] | op_q[3]) : carry;

endmodule

// File: tb/tb_nanov_alu_seq.sv
// Bench for nanov_alu_seq: behavioural 1-bit slice plus an arithmetic reference model with random and directed stimulus.
module tb_nanov_alu_seq;
  localparam int XLEN = 32;
`ifdef NANOV_ALU_SEQ_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      op = 4'h0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            abort = 1'b0;
  logic            busy, done;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_op;
  logic            alu_a, alu_b, alu_cy_in, alu_d, alu_cy_out, alu_lts;

  int errors = 0;
  int checks = 0;

  // Model: cycles remaining until IDLE (0 = idle, 1 = done cycle), visible result, in-flight result.
  int              m_left = 0;
  logic [XLEN-1:0] m_res = '0;
  logic [XLEN-1:0] m_pend = '0;

  always #5 clk = ~clk;

  nanov_alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
`ifdef NANOV_ALU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cy_in(alu_cy_in),
    .alu_d(alu_d), .alu_cy_out(alu_cy_out), .alu_lts(alu_lts)
  );

  // Behavioural 1-bit ALU slice
  always_comb begin
    logic inv, bx, s;
    inv = (alu_op == 4'b1000) || (alu_op == 4'b0010) || (alu_op == 4'b0011);
    bx  = alu_b ^ inv;
    s   = alu_a ^ bx ^ alu_cy_in;
    alu_cy_out = (alu_a & bx) | (alu_a & alu_cy_in) | (bx & alu_cy_in);
    alu_lts    = (alu_a != alu_b) ? alu_a : s;
    case (alu_op)
      4'b0000, 4'b1000, 4'b0010, 4'b0011: alu_d = s;
      4'b0111: alu_d = alu_a & alu_b;
      4'b0110: alu_d = alu_a | alu_b;
      4'b0100: alu_d = alu_a ^ alu_b;
      default: alu_d = 1'b0;
    endcase
  end

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    case (o)
      4'b0000: return x + y;
      4'b1000: return x - y;
      4'b0010: return ($signed(x) < $signed(y)) ? 1 : 0;
      4'b0011: return (x < y) ? 1 : 0;
      4'b0111: return x & y;
      4'b0110: return x | y;
      4'b0100: return x ^ y;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] tbl [7] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100};
    int unsigned k = $urandom_range(0, 8);
    if (k < 7) return tbl[k];
    return 4'($urandom);
  endfunction

  function automatic logic [XLEN-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge: drive inputs, advance the model over one posedge, check at the next negedge.
  task automatic cycle(input logic st, input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input logic ab);
    start = st; op = o; a = x; b = y; abort = ab;
    if (m_left == 0) begin
      if (st) begin
        m_pend = ref_alu(o, x, y);
        m_left = XLEN + 1;
      end
    end else if (ABORT_ON && ab && m_left > 1) begin
      m_left = 0;
    end else begin
      m_left--;
      if (m_left == 1) m_res = m_pend;
    end
    @(posedge clk);
    @(negedge clk);
    check("busy", busy, m_left > 1);
    check("done", done, m_left == 1);
    check("result", result, m_res);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, rand_op(), $urandom, $urandom, 1'b0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] exp, input string tag);
    int n = 0;
    cycle(1'b1, o, x, y, 1'b0);
    while (done !== 1'b1 && n < XLEN + 8) begin
      idle_cycle();
      n++;
    end
    // DONE is entered on the XLEN-th edge after the accepting edge.
    check({tag, "_lat"}, n, XLEN);
    check(tag, result, exp);
    idle_cycle();
  endtask

  task automatic drain();
    int k = 0;
    while (m_left != 0 && k < XLEN + 8) begin
      idle_cycle();
      k++;
    end
    check("drain", m_left, 0);
  endtask

  initial begin
    int ndone;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    rstn = 1'b1;
    @(negedge clk);

    run_op(4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, "add");
    run_op(4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub");
    run_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg");
    run_op(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big");
    run_op(4'b0011, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, "sltu_lt");
    run_op(4'b0010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, "slt_eq");
    run_op(4'b0111, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, "and");
    run_op(4'b0110, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, "or");
    run_op(4'b0100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, "xor");
    run_op(4'b0001, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, "undef");

    // start held high: accepts at cycles 0, 34, 68 -> dones visible after cycles 32 and 66.
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, rand_op(), rand_opnd(), rand_opnd(), 1'b0);
      if (done === 1'b1) ndone++;
    end
    check("back_to_back_dones", ndone, 2);
    drain();

    // Reset during RUN bit 10
    cycle(1'b1, 4'b0000, 32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (10) idle_cycle();
    start = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, '0);
    m_left = 0;
    m_res  = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op(4'b1000, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, "after_rst");

    if (ABORT_ON) begin
      run_op(4'b0000, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, "pre_abort");
      cycle(1'b1, 4'b0110, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
      repeat (10) idle_cycle();
      cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      check("abort_result", result, 32'h0000_0123);
      repeat (3) idle_cycle();
      // Abort coinciding with the last RUN bit
      cycle(1'b1, 4'b0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
      repeat (XLEN - 1) idle_cycle();
      cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      check("abort_last_result", result, 32'h0000_0123);
      run_op(4'b1000, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, "post_abort");
    end

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, rand_op(), rand_opnd(), rand_opnd(),
            ABORT_ON && ($urandom_range(0, 40) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nanov_alu_seq.md
Name: nanov_alu_seq

Overview:
- Sequencer for the nanoV bit-serial ALU.
- Accepts one parallel XLEN-bit operation: latches op, A and B, then streams the operands LSB-first through the 1-bit ALU slice over XLEN cycles.
- Threads the carry between cycles and assembles the parallel result, including the SLT/SLTU fix-up on the final bit.
- Sits between the core's decode/register-read stage and the ALU slice, which is instantiated outside this block.

Parameters:
- XLEN, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  4  ALU opcode: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0111 AND, 0110 OR, 0100 XOR
- a  input  XLEN  operand A
- b  input  XLEN  operand B
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result becomes valid
- result  output  XLEN  last completed result, held until the next completion
- alu_op  output  4  to slice; the latched opcode
- alu_a  output  1  to slice; A shift register bit 0
- alu_b  output  1  to slice; B shift register bit 0
- alu_cy_in  output  1  to slice; carry in
- alu_d  input  1  from slice; result bit
- alu_cy_out  input  1  from slice; carry out
- alu_lts  input  1  from slice; signed less-than on final bit

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (clk, rstn).
- Reset values:
  - State IDLE; busy=0, done=0, result=0.
  - Counter=0, carry register=0, operand/op registers=0.
- States:
  - IDLE:
    - start=1 → latch op, a, b; counter←0; go RUN.
    - start=0 → stay in IDLE.
  - RUN: one bit per cycle.
    - Shift A and B right by 1.
    - Shift alu_d into result shift register at MSB side (LSB-first assembly).
    - Carry register ← alu_cy_out.
    - Counter +1.
    - When counter==XLEN-1 → go DONE.
  - DONE: one cycle; done=1 → IDLE.
- Carry rule:
  - alu_cy_in = (op[1] | op[3]) on the first RUN cycle (counter==0); this is the +1 of two's-complement subtract.
  - On every later cycle, alu_cy_in = carry register.
- Final-bit fix-up, on the cycle with counter==XLEN-1:
  - SLT (0010): result ← {XLEN-1 zeros, alu_lts}.
  - SLTU (0011): result ← {XLEN-1 zeros, ~alu_cy_out}; no carry means A<B.
  - All other ops: result ← assembled shift value including the final alu_d.
- result register:
  - Updates only at the RUN→DONE transition.
  - Stable during RUN; no partial values are visible.
- Latency: start accepted at edge N → done=1 in cycle N+XLEN+1 → IDLE again at N+XLEN+2.
- Throughput: one operation per XLEN+2 cycles.
- start while busy or in DONE: ignored, not queued.
- a/b/op changes after acceptance: no effect.
- Undefined opcodes: sequenced normally; result = whatever the slice returns, i.e. 0.
- Reset asserted mid-RUN: immediate return to IDLE; result=0, no done.
- alu_op/alu_a/alu_b are driven from registers in all states; they are don't-care outside RUN.

Optional Feature:
- Macro: NANOV_ALU_SEQ_ABORT_EN.
- With the macro: extra input port abort (1 bit).
  - abort=1 in RUN → IDLE at the next edge; no done; result unchanged; carry register cleared.
  - abort in the same cycle as the last RUN bit: abort wins.
  - abort in IDLE/DONE: ignored; in DONE, done still pulses.
- Without the macro: no abort port; every accepted operation runs to completion.

Test Plan:
- ADD, a=0x0000_0005, b=0x0000_0003 → done exactly 33 cycles after accept; result=0x0000_0008.
- SUB, a=0x0000_0000, b=0x0000_0001 → result=0xFFFF_FFFF. ADD, a=0xFFFF_FFFF, b=1 → result=0; confirms carry threading and first-cycle cy_in.
- SLT, a=0xFFFF_FFFF (−1), b=1 → 1. SLTU, same operands → 0. SLTU, a=3, b=5 → 1. SLT, a=5, b=5 → 0.
- AND/OR/XOR, a=0xF0F0_A5A5, b=0x0FF0_FFFF → 0x00F0_A5A5 / 0xFFF0_FFFF / 0xFF00_5A5A.
- start pulsed every cycle for 100 cycles with varying operands → exactly one done per 34 cycles; each result matches the operands latched at its accept; busy=1 throughout RUN.
- rstn dropped at RUN bit 10 → busy=0 and result=0 immediately. With NANOV_ALU_SEQ_ABORT_EN: abort at bit 10 → no done, prior result retained, next op correct.
